// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Memory-mapped interrupt controller with edge/level sources,
//            enable mask, priority vector and registered active-low nIRQ.
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int          NSRC      = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     memaddr,
  input  logic            memwrite,
  input  logic [3:0]      be,
  input  logic [31:0]     writedata,
  output logic            sel,
  output logic [31:0]     rdata,
  output logic            nIRQ
);

  localparam logic [7:0] c_OFF_PEND   = 8'h00;
  localparam logic [7:0] c_OFF_ENABLE = 8'h04;
  localparam logic [7:0] c_OFF_CLEAR  = 8'h08;
  localparam logic [7:0] c_OFF_ACTIVE = 8'h0C;
  localparam logic [7:0] c_OFF_VECTOR = 8'h10;
  localparam logic [7:0] c_OFF_SOFT   = 8'h14;
  localparam logic [7:0] c_OFF_TRIG   = 8'h18;

  logic [NSRC-1:0] r_sync1;
  logic [NSRC-1:0] r_sync2;
  logic [NSRC-1:0] r_sync3;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_enable;
  logic [NSRC-1:0] r_trig;
  logic            r_nirq;

  logic [7:0]      w_off;
  logic            w_wr;
  logic [NSRC-1:0] w_set_hw;
  logic [NSRC-1:0] w_set_soft;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_active;
  logic [4:0]      w_vec_idx;
  logic [31:0]     w_vector;
  logic            w_unused;

  function automatic logic [31:0] f_zext(input logic [NSRC-1:0] v);
    f_zext = '0;
    f_zext[NSRC-1:0] = v;
  endfunction

  assign sel      = (memaddr[31:8] == BASE_ADDR[31:8]);
  assign w_off    = memaddr[7:0];
  assign w_wr     = sel & memwrite & (be == 4'b1111);
  assign w_unused = ^writedata[31:NSRC];

  // r_sync2 is the synchronised line, r_sync3 its one-cycle-old copy
  assign w_set_hw   = (r_trig & r_sync2 & ~r_sync3) | (~r_trig & r_sync2);
  assign w_set_soft = (w_wr && (w_off == c_OFF_SOFT))  ? writedata[NSRC-1:0] : '0;
  assign w_clr      = (w_wr && (w_off == c_OFF_CLEAR)) ? writedata[NSRC-1:0] : '0;
  assign w_active   = r_pend & r_enable;

  // Scan downwards so the lowest-index active source is the last to win
  always_comb begin
    w_vec_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_vec_idx = 5'(i);
      end
    end
  end

  assign w_vector = {|w_active, 26'd0, w_vec_idx};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_sync3  <= '0;
      r_pend   <= '0;
      r_enable <= '0;
      r_trig   <= '1;
      r_nirq   <= 1'b1;
    end else begin
      r_sync1 <= src;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      // Sets are OR-ed in after the clear so a coincident event is kept
      r_pend  <= (r_pend & ~w_clr) | w_set_hw | w_set_soft;
      r_nirq  <= ~|w_active;
      if (w_wr && (w_off == c_OFF_ENABLE)) begin
        r_enable <= writedata[NSRC-1:0];
      end
      if (w_wr && (w_off == c_OFF_TRIG)) begin
        r_trig <= writedata[NSRC-1:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (w_off)
        c_OFF_PEND:   rdata = f_zext(r_pend);
        c_OFF_ENABLE: rdata = f_zext(r_enable);
        c_OFF_ACTIVE: rdata = f_zext(w_active);
        c_OFF_VECTOR: rdata = w_vector;
        c_OFF_TRIG:   rdata = f_zext(r_trig);
        default:      rdata = '0;
      endcase
    end
  end

  assign nIRQ = r_nirq;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Self-checking bench for irq_controller against a cycle-level
//            reference model built from the register-map rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  localparam int          NSRC = 8;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic [7:0]  src;
  logic [31:0] memaddr;
  logic        memwrite;
  logic [3:0]  be;
  logic [31:0] writedata;
  logic        sel;
  logic [31:0] rdata;
  logic        nIRQ;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  irq_controller #(.NSRC(NSRC), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .src(src), .memaddr(memaddr),
    .memwrite(memwrite), .be(be), .writedata(writedata),
    .sel(sel), .rdata(rdata), .nIRQ(nIRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: state as seen between clock edges
  logic [7:0] m_pend, m_en, m_trig;
  logic       m_nirq;
  logic [7:0] hist [3];   // src sampled at the last three edges, [0] newest
  logic [7:0] m_ev, m_clr, m_soft;
  logic       m_wr;

  function automatic logic [31:0] mread(input logic [31:0] a);
    logic [7:0]  act;
    logic [31:0] vec;
    act = m_pend & m_en;
    vec = 32'd0;
    for (int i = 0; i < 8; i++) begin
      if (act[i]) begin
        vec = 32'h8000_0000 | i;
        break;
      end
    end
    if (a[31:8] != BASE[31:8]) return 32'd0;
    case (a[7:0])
      8'h00:   return {24'd0, m_pend};
      8'h04:   return {24'd0, m_en};
      8'h0C:   return {24'd0, act};
      8'h10:   return vec;
      8'h18:   return {24'd0, m_trig};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend = 8'h00; m_en = 8'h00; m_trig = 8'hFF; m_nirq = 1'b1;
      for (int i = 0; i < 3; i++) hist[i] = 8'h00;
    end else begin
      m_nirq = ((m_pend & m_en) == 8'h00);
      // A line seen at the pending logic is the src value from two edges ago
      for (int i = 0; i < 8; i++)
        m_ev[i] = m_trig[i] ? (hist[1][i] && !hist[2][i]) : hist[1][i];
      m_wr   = (memaddr[31:8] == BASE[31:8]) && memwrite && (be == 4'hF);
      m_clr  = (m_wr && memaddr[7:0] == 8'h08) ? writedata[7:0] : 8'h00;
      m_soft = (m_wr && memaddr[7:0] == 8'h14) ? writedata[7:0] : 8'h00;
      m_pend = (m_pend & ~m_clr) | m_ev | m_soft;
      if (m_wr && memaddr[7:0] == 8'h04) m_en   = writedata[7:0];
      if (m_wr && memaddr[7:0] == 8'h18) m_trig = writedata[7:0];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = src;
    end
  end

  always @(negedge clk) begin
    if (chk_on) chk("nirq", {31'd0, nIRQ}, {31'd0, m_nirq});
  end

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    memaddr = a; writedata = d; be = b; memwrite = 1'b1;
    @(negedge clk);
    memwrite = 1'b0; be = 4'hF;
  endtask

  task automatic read_reg(input string tag, input logic [31:0] a, output logic [31:0] v);
    memaddr = a; memwrite = 1'b0;
    #1;
    chk(tag, rdata, mread(a));
    v = rdata;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [31:0] v;
  logic [7:0]  offs [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40};

  initial begin
    reset = 1'b0; src = 8'hFF; memaddr = BASE; memwrite = 1'b0; be = 4'hF; writedata = '0;
    cycles(2);
    chk_on = 1;
    // Reset values with sources held high
    chk("rst_nirq", {31'd0, nIRQ}, 32'd1);
    read_reg("rst_pend", BASE + 32'h00, v);   chk("rst_pend_c", v, 32'h0);
    read_reg("rst_en", BASE + 32'h04, v);     chk("rst_en_c", v, 32'h0);
    read_reg("rst_trig", BASE + 32'h18, v);   chk("rst_trig_c", v, 32'hFF);
    @(negedge clk); reset = 1'b1;
    cycles(4);
    read_reg("rel_pend", BASE + 32'h00, v);   chk("rel_pend_c", v, 32'hFF);
    chk("rel_nirq", {31'd0, nIRQ}, 32'd1);
    src = 8'h00;
    bus_write(BASE + 32'h08, 32'hFF, 4'hF);

    // Edge latency on src[2]
    bus_write(BASE + 32'h04, 32'h04, 4'hF);
    src = 8'h04; @(negedge clk); src = 8'h00;
    @(negedge clk);
    read_reg("lat_pend_k1", BASE, v);         chk("lat_pend_k1_c", v, 32'h00);
    @(negedge clk);
    read_reg("lat_pend_k2", BASE, v);         chk("lat_pend_k2_c", v, 32'h04);
    chk("lat_nirq_k2", {31'd0, nIRQ}, 32'd1);
    @(negedge clk);
    chk("lat_nirq_k3", {31'd0, nIRQ}, 32'd0);
    read_reg("lat_vec", BASE + 32'h10, v);    chk("lat_vec_c", v, 32'h8000_0002);
    bus_write(BASE + 32'h08, 32'h04, 4'hF);
    @(negedge clk);
    chk("lat_clr_nirq", {31'd0, nIRQ}, 32'd1);

    // Priority vector
    bus_write(BASE + 32'h04, 32'hFF, 4'hF);
    bus_write(BASE + 32'h14, 32'hA0, 4'hF);
    read_reg("pri_vec1", BASE + 32'h10, v);   chk("pri_vec1_c", v, 32'h8000_0005);
    bus_write(BASE + 32'h08, 32'h20, 4'hF);
    read_reg("pri_vec2", BASE + 32'h10, v);   chk("pri_vec2_c", v, 32'h8000_0007);
    bus_write(BASE + 32'h08, 32'hFF, 4'hF);

    // Hardware set coincides with CLEAR on bit 1
    bus_write(BASE + 32'h14, 32'h02, 4'hF);
    src = 8'h02;
    cycles(2);
    bus_write(BASE + 32'h08, 32'h02, 4'hF);
    read_reg("col_pend", BASE, v);            chk("col_pend_c", v, 32'h02);
    chk("col_nirq0", {31'd0, nIRQ}, 32'd0);
    @(negedge clk);
    chk("col_nirq1", {31'd0, nIRQ}, 32'd0);
    src = 8'h00;
    cycles(3);
    bus_write(BASE + 32'h08, 32'hFF, 4'hF);

    // Level mode on source 0
    bus_write(BASE + 32'h18, 32'hFE, 4'hF);
    src = 8'h01;
    cycles(3);
    bus_write(BASE + 32'h08, 32'h01, 4'hF);
    read_reg("lvl_hold", BASE, v);            chk("lvl_hold_c", v, 32'h01);
    src = 8'h00;
    cycles(3);
    bus_write(BASE + 32'h08, 32'h01, 4'hF);
    read_reg("lvl_clr", BASE, v);             chk("lvl_clr_c", v, 32'h00);
    @(negedge clk);
    chk("lvl_nirq", {31'd0, nIRQ}, 32'd1);

    // Bus filtering
    bus_write(BASE + 32'h04, 32'h55, 4'b0011);
    read_reg("bus_be", BASE + 32'h04, v);     chk("bus_be_c", v, 32'hFF);
    chk("bus_sel1", {31'd0, sel}, 32'd1);
    memaddr = BASE + 32'h104; #1;
    chk("bus_sel0", {31'd0, sel}, 32'd0);
    chk("bus_rd0", rdata, 32'd0);
    bus_write(BASE + 32'h104, 32'h55, 4'hF);
    read_reg("bus_win", BASE + 32'h04, v);    chk("bus_win_c", v, 32'hFF);

    // Randomised traffic with one asynchronous reset in the middle
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        #2 reset = 1'b0;
        #1 chk("mid_rst_nirq", {31'd0, nIRQ}, 32'd1);
        read_reg("mid_rst_pend", BASE, v);
        @(negedge clk);
        reset = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) src = src ^ 8'(1 << $urandom_range(0, 7));
      memaddr   = (($urandom_range(0, 9) == 0) ? (BASE ^ 32'h100) : BASE)
                  | {24'd0, offs[$urandom_range(0, 8)]};
      writedata = $urandom;
      be        = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      memwrite  = ($urandom_range(0, 3) == 0);
      #1;
      chk("rnd_sel", {31'd0, sel}, {31'd0, memaddr[31:8] == BASE[31:8]});
      chk("rnd_rdata", rdata, mread(memaddr));
      @(negedge clk);
    end
    memwrite = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
